// File: rtl/qbert_map_pkg.sv
// Shared definitions for the Qbert pyramid cube colour logic.
package qbert_map_pkg;

  localparam int unsigned N_CUBE = 28;
  // Wide enough for a full pyramid count (max 28).
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    CHECK,
    FLASH,
    DONE
  } ctrl_state_t;

  // Number of set bits in a cube vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_CUBE-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CUBE; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
// Purely combinational; the pointer register is owned by the caller.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan requesters starting at the pointer, wrapping around.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = PTR_W'((int'(ptr) + i) % int'(N_REQ));
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cube_color_controller.sv
// Owns the cube top-colour vector: arbitrates paint/revert requests,
// applies them, tracks the painted count and runs the completion flash.
module cube_color_controller
  import qbert_map_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned FLASH_CYCLES  = 4_125_000,
  parameter int unsigned FLASH_TOGGLES = 6
) (
  input  logic                    CLK_33,
  input  logic                    reset,
  input  logic                    e_load,
  input  logic [N_CUBE-1:0]       e_color_init,
  input  logic                    e_toggle_mode,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*N_CUBE-1:0] req_pos,
  input  logic [N_REQ-1:0]        req_paint,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_CUBE-1:0]       color_state,
  output logic [CNT_W-1:0]        painted_cnt,
  output logic                    flash,
  output logic                    level_done,
  output logic                    pos_err,
  output logic                    busy
);

  localparam int unsigned PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [22:0] FLASH_LAST = 23'(FLASH_CYCLES - 1);
  localparam logic [2:0]  TOG_LAST   = 3'(FLASH_TOGGLES - 1);

  ctrl_state_t       state_q, state_d;
  logic [N_CUBE-1:0] color_q, color_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flash_q, flash_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_CUBE-1:0] lat_pos_q, lat_pos_d;
  logic              lat_paint_q, lat_paint_d;
  logic [22:0]       fcnt_q, fcnt_d;
  logic [2:0]        tog_q, tog_d;

  logic              arb_en;
  logic [N_REQ-1:0]  grant;
  logic [N_CUBE-1:0] sel_pos;
  logic              sel_paint;
  logic [PTR_W-1:0]  ptr_next;
  logic              pos_ok;

  // Grants only from IDLE; a load or reset cycle never hands out a grant.
  assign arb_en = (state_q == IDLE) && !e_load && !reset;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req  (req_valid),
    .ptr  (ptr_q),
    .en   (arb_en),
    .grant(grant)
  );

  assign req_ready   = grant;
  assign color_state = color_q;
  assign painted_cnt = cnt_q;
  assign flash       = flash_q;
  assign level_done  = done_q;
  assign pos_err     = err_q;
  assign busy        = (state_q != IDLE);

  assign pos_ok = (popcount(lat_pos_q) == CNT_W'(1));

  // Select the winner's request and the pointer slot just after it.
  always_comb begin
    sel_pos   = '0;
    sel_paint = 1'b0;
    ptr_next  = ptr_q;
    for (int r = 0; r < int'(N_REQ); r++) begin
      if (grant[r]) begin
        sel_pos   = req_pos[r*N_CUBE +: N_CUBE];
        sel_paint = req_paint[r];
        ptr_next  = PTR_W'((r + 1) % int'(N_REQ));
      end
    end
  end

  // Next-state and datapath updates; e_load overrides every state.
  always_comb begin
    state_d     = state_q;
    color_d     = color_q;
    cnt_d       = cnt_q;
    flash_d     = flash_q;
    done_d      = done_q;
    err_d       = err_q;
    ptr_d       = ptr_q;
    lat_pos_d   = lat_pos_q;
    lat_paint_d = lat_paint_q;
    fcnt_d      = fcnt_q;
    tog_d       = tog_q;

    if (e_load) begin
      state_d = IDLE;
      color_d = e_color_init;
      cnt_d   = popcount(e_color_init);
      flash_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ptr_d   = '0;
      fcnt_d  = '0;
      tog_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            lat_pos_d   = sel_pos;
            lat_paint_d = sel_paint;
            ptr_d       = ptr_next;
            state_d     = UPDATE;
          end
        end
        UPDATE: begin
          if (!pos_ok) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            if (!lat_paint_q) begin
              color_d = color_q & ~lat_pos_q;
            end else if (e_toggle_mode) begin
              color_d = color_q ^ lat_pos_q;
            end else begin
              color_d = color_q | lat_pos_q;
            end
            state_d = CHECK;
          end
        end
        CHECK: begin
          cnt_d = popcount(color_q);
          if (&color_q) begin
            state_d = FLASH;
            flash_d = 1'b1;
            fcnt_d  = '0;
            tog_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        FLASH: begin
          if (fcnt_q == FLASH_LAST) begin
            fcnt_d = '0;
            // The last half-period ends the flash instead of toggling again.
            if (tog_q == TOG_LAST) begin
              flash_d = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              tog_d   = tog_q + 3'd1;
              flash_d = ~flash_q;
            end
          end else begin
            fcnt_d = fcnt_q + 23'd1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK_33 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Colour, flag, pointer and flash-timer registers.
  always_ff @(posedge CLK_33 or posedge reset) begin
    if (reset) begin
      color_q     <= '0;
      cnt_q       <= '0;
      flash_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ptr_q       <= '0;
      lat_pos_q   <= '0;
      lat_paint_q <= 1'b0;
      fcnt_q      <= '0;
      tog_q       <= '0;
    end else begin
      color_q     <= color_d;
      cnt_q       <= cnt_d;
      flash_q     <= flash_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      lat_pos_q   <= lat_pos_d;
      lat_paint_q <= lat_paint_d;
      fcnt_q      <= fcnt_d;
      tog_q       <= tog_d;
    end
  end

endmodule

// File: doc/cube_color_controller.md
# cube_color_controller

Sequencer and owner of the 28-bit cube top-colour state for the Qbert pyramid. It arbitrates paint/revert requests from multiple movers (Qbert, reverting enemies), applies them to the colour vector, counts painted cubes and detects level completion. It then runs a timed completion flash. Its `color_state` output drives `e_color_state` of the map/colour renderer, replacing direct Nios writes; Nios only loads an initial pattern.

## Interface
Parameters:
- `N_CUBE`, 28: number of cubes; bit i = cube i, same indexing as `position_qb`.
- `N_REQ`, 2: number of requesters; index 0 = Qbert, highest priority on ties after reset.
- `FLASH_CYCLES`, 4_125_000: half-period of completion flash, in `CLK_33` cycles (125 ms).
- `FLASH_TOGGLES`, 6: number of flash half-periods before `level_done`.

Ports:
- `CLK_33` in 1: system clock, 33 MHz.
- `reset` in 1: asynchronous, active-high.
- `e_load` in 1: Nios pulse; load `e_color_init`, clear flags, abort any activity.
- `e_color_init` in N_CUBE: initial colour pattern.
- `e_toggle_mode` in 1: 0 = paint sets bit; 1 = paint toggles bit.
- `req_valid` in N_REQ: request pending; held until accepted.
- `req_pos` in N_REQ×N_CUBE: one-hot landing cube per requester (packed, requester r at `[r*N_CUBE +: N_CUBE]`).
- `req_paint` in N_REQ: 1 = paint, 0 = revert (clear bit).
- `req_ready` out N_REQ: accept strobe; handshake occurs when `req_valid[r] & req_ready[r]`.
- `color_state` out N_CUBE: current top colours (1 = painted).
- `painted_cnt` out 5: popcount of `color_state`.
- `flash` out 1: flash phase; renderer shows inverted tops while high.
- `level_done` out 1: sticky; all cubes painted and flash finished.
- `pos_err` out 1: sticky; a request with zero or multi-hot `req_pos` was accepted.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, UPDATE, CHECK, FLASH, DONE.
- IDLE:
  - If any `req_valid`, the round-robin arbiter (`rr_arbiter`) grants one requester and drives its `req_ready` high for that cycle only.
  - The winner's pos and paint bit are latched, and the FSM goes to UPDATE.
  - The arbiter pointer advances to winner+1 mod N_REQ.
- UPDATE:
  - If the latched pos is not exactly one-hot: set `pos_err`, make no change, go to IDLE.
  - Otherwise apply to `color_state`:
    - Paint with `e_toggle_mode`=0: OR in the bit.
    - Paint with `e_toggle_mode`=1: XOR in the bit.
    - Revert: AND with the inverse of the bit.
  - Go to CHECK.
- CHECK: register `painted_cnt` = popcount. If `color_state` is all ones, go to FLASH and clear the flash counter; otherwise go to IDLE.
- FLASH:
  - `req_ready` is held low.
  - `flash` toggles every FLASH_CYCLES cycles, starting high on entry.
  - After FLASH_TOGGLES toggles, `flash` = 0, `level_done` = 1, go to DONE.
- DONE: ignore all requests (`req_ready` = 0) until `e_load`.
- `e_load`:
  - Highest priority in any state. Next edge: `color_state` = `e_color_init`, `painted_cnt` = popcount(`e_color_init`), `flash`/`level_done`/`pos_err` = 0, FSM to IDLE, arbiter pointer = 0.
  - No `req_ready` is asserted in an `e_load` cycle.
  - Loading an all-ones pattern does not flash; the next accepted request enters CHECK normally.
- Reset values: `color_state` 0, `painted_cnt` 0, `flash` 0, `level_done` 0, `pos_err` 0, `busy` 0, `req_ready` 0, FSM IDLE, pointer 0.
- Widths: popcount fits 5 bits (max 28). Flash counter is 23 bits; toggle counter is 3 bits. No overflow paths.

## Timing
- `req_ready` is combinational from FSM state, `req_valid` and pointer. It is never high outside IDLE.
- Handshake in cycle T:
  - `color_state` changes at edge T+2.
  - `painted_cnt` updates at edge T+3.
  - Next grant no earlier than cycle T+3, so the throughput is 1 request per 3 cycles.
- Requests arriving during UPDATE/CHECK wait; they are not lost, since the requester holds `req_valid`.
- Simultaneous requests: the grant goes to the first valid index at or after the pointer. A paint and a revert on the same cube are served in that order, last one wins.
- Flash duration: FLASH_TOGGLES×FLASH_CYCLES cycles from entering FLASH. `level_done` rises on the following edge.
- Reset mid-operation clears everything asynchronously. A pending `req_valid` is regranted after reset release.

## Structure
- `qbert_map_pkg`: `N_CUBE`, `ctrl_state_t` enum (IDLE, UPDATE, CHECK, FLASH, DONE), popcount function.
- Sub-module `rr_arbiter` #(N_REQ): inputs `req`, `ptr`, `en`; outputs one-hot `grant`. Pointer register lives in the controller.

## Test plan
- `e_load` with 0x0000000, then Qbert paints pos bit 5 -> `req_ready[0]` 1 cycle; `color_state` = 0x0000020 at T+2; `painted_cnt` = 1 at T+3.
- Both requesters valid every cycle: req0 paints bit 3, req1 reverts bit 3 -> grants alternate 0,1,0; final `color_state` bit 3 follows the last grant; 3-cycle spacing between grants.
- Load 0xFFFFFFE, paint bit 0 -> CHECK enters FLASH; `flash` high for FLASH_CYCLES then toggles; `level_done` = 1 after 6×FLASH_CYCLES; requests not accepted in FLASH or DONE (use small FLASH_CYCLES = 4).
- `e_toggle_mode` = 1, paint bit 10 twice -> bit 10 = 1 then 0; `painted_cnt` 1 then 0.
- `req_pos` = 0x0000003 (two-hot) -> accepted, `pos_err` = 1, `color_state` unchanged; cleared by `e_load`.
- Assert `reset` during FLASH -> all outputs 0 immediately; `e_load` during FLASH -> `flash` 0 next edge, FSM IDLE.
